// File: rtl/mcb_port_arbiter.sv
// mcb_port_arbiter: N-channel arbiter/sequencer driving one MCB user port (cmd/wr/rd FIFOs)
module mcb_port_arbiter #(
    parameter int NCH     = 3,
    parameter int ADDR_W  = 30,
    parameter int DATA_W  = 128,
    parameter int BL_W    = 6,
    parameter int RR      = 0,
    parameter int TIMEOUT = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  calib_done,
    input  logic [NCH-1:0]        ch_req,
    input  logic [NCH-1:0]        ch_we,
    input  logic [NCH*ADDR_W-1:0] ch_addr,
    input  logic [NCH*BL_W-1:0]   ch_bl,
    output logic [NCH-1:0]        ch_busy,
    output logic [NCH-1:0]        ch_wd_rd,
    input  logic [NCH*DATA_W-1:0] ch_wdata,
    output logic [DATA_W-1:0]     rd_data,
    output logic [NCH-1:0]        rd_valid,
    output logic [BL_W-1:0]       rd_beat,
    output logic                  cmd_en,
    output logic [2:0]            cmd_instr,
    output logic [ADDR_W-1:0]     cmd_byte_addr,
    output logic [BL_W-1:0]       cmd_bl,
    output logic                  wr_en,
    output logic [DATA_W-1:0]     wr_data,
    input  logic                  wr_empty,
    output logic                  rd_en,
    input  logic [DATA_W-1:0]     rd_data_mcb,
    input  logic                  rd_empty,
    output logic                  wdog_err
);
    localparam int GW = $clog2(NCH);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, WFILL, WCMD, WDRAIN, RWAIT, RSTREAM, DONE} state_t;

    state_t          state;
    logic [NCH-1:0]  req_m, req_s, armed, elig;
    logic [GW-1:0]   ptr, gsel, gnt;
    logic            gnt_v;
    logic [BL_W-1:0] cnt;
    logic [TW-1:0]   wcnt;

    // The beat comes straight from the owning channel in the cycle wr_en is high
    assign wr_data = wr_en ? ch_wdata[gsel*DATA_W +: DATA_W] : '0;

    // A write channel is only worth granting when the MCB write FIFO is empty
    always_comb begin
        for (int i = 0; i < NCH; i++)
            elig[i] = req_s[i] & armed[i] & (~ch_we[i] | wr_empty);
    end

    // Highest-priority eligible channel; the last hit in the scan has top priority
    always_comb begin
        int idx;
        gnt_v = 1'b0;
        gnt   = '0;
        idx   = 0;
        for (int j = NCH; j >= 1; j--) begin
            idx = RR != 0 ? (int'(ptr) + j) % NCH : j - 1;
            if (elig[idx]) begin
                gnt_v = 1'b1;
                gnt   = GW'(idx);
            end
        end
    end

    // Request sync, arming, burst sequencing and watchdog
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            req_m         <= '0;
            req_s         <= '0;
            armed         <= '1;
            ptr           <= GW'(NCH - 1);
            gsel          <= '0;
            cnt           <= '0;
            wcnt          <= '0;
            ch_busy       <= '0;
            ch_wd_rd      <= '0;
            rd_data       <= '0;
            rd_valid      <= '0;
            rd_beat       <= '0;
            cmd_en        <= 1'b0;
            cmd_instr     <= '0;
            cmd_byte_addr <= '0;
            cmd_bl        <= '0;
            wr_en         <= 1'b0;
            rd_en         <= 1'b0;
            wdog_err      <= 1'b0;
        end else begin
            req_m    <= ch_req;
            req_s    <= req_m;
            armed    <= armed | ~req_s;
            cmd_en   <= 1'b0;
            wr_en    <= 1'b0;
            rd_valid <= '0;
            ch_wd_rd <= '0;
            wcnt     <= '0;
            case (state)
                IDLE: if (calib_done && gnt_v) begin
                    gsel          <= gnt;
                    ptr           <= gnt;
                    ch_busy       <= NCH'(1) << gnt;
                    cmd_byte_addr <= ch_addr[gnt*ADDR_W +: ADDR_W];
                    cmd_bl        <= ch_bl[gnt*BL_W +: BL_W];
                    cmd_instr     <= ch_we[gnt] ? 3'b000 : 3'b001;
                    cnt           <= '0;
                    if (ch_we[gnt]) begin
                        ch_wd_rd <= NCH'(1) << gnt;
                        state    <= WFILL;
                    end else begin
                        cmd_en <= 1'b1;
                        state  <= RWAIT;
                    end
                end
                WFILL: begin
                    wr_en <= |ch_wd_rd;
                    if (|ch_wd_rd) begin
                        if (cnt != cmd_bl) begin
                            ch_wd_rd <= ch_busy;
                            cnt      <= cnt + 1'b1;
                        end
                    end else begin
                        cmd_en      <= 1'b1;
                        ch_busy     <= '0;
                        armed[gsel] <= ~req_s[gsel];
                        state       <= WCMD;
                    end
                end
                WCMD: state <= WDRAIN;
                WDRAIN: begin
                    if (wr_empty) state <= IDLE;
                    else if (wcnt == TW'(TIMEOUT - 1)) begin
                        wdog_err <= 1'b1;
                        state    <= IDLE;
                    end else wcnt <= wcnt + 1'b1;
                end
                RWAIT: begin
                    if (!rd_empty) begin
                        rd_en <= 1'b1;
                        state <= RSTREAM;
                    end else if (wcnt == TW'(TIMEOUT - 1)) begin
                        wdog_err    <= 1'b1;
                        ch_busy     <= '0;
                        armed[gsel] <= ~req_s[gsel];
                        state       <= IDLE;
                    end else wcnt <= wcnt + 1'b1;
                end
                RSTREAM: if (!rd_empty) begin
                    rd_data  <= rd_data_mcb;
                    rd_valid <= ch_busy;
                    rd_beat  <= cnt;
                    cnt      <= cnt + 1'b1;
                    if (cnt == cmd_bl) begin
                        rd_en <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    ch_busy     <= '0;
                    armed[gsel] <= ~req_s[gsel];
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
